mips_core_exec: RTL and testbench
=================================

Name: mips_core_exec

Overview:
- Single-cycle MIPS-subset execution core: main/ALU control decoder, 32-bit ALU, PC register, PC+4 / branch-target adders, next-PC and writeback selection.
- Sits between instruction memory, register file and data memory; those storage blocks stay external.
- Everything is combinational except the PC register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- LINK_REG, 5'd7, register used as link register by jal and as jump source by jr.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces PC to RESET_PC
- instr  in  32  current instruction (imem data at pc_q)
- rd1  in  32  register-file read data, port 1
- rd2  in  32  register-file read data, port 2
- mem_rd  in  32  data-memory read data
- pc_q  out  32  current PC (imem address)
- pc_d  out  32  next PC
- ra1  out  5  register read address 1
- ra2  out  5  register read address 2 = instr[20:16]
- wa3  out  5  register write address
- reg_write  out  1  register write enable
- wd3  out  32  register write data
- mem_write  out  1  data-memory write enable
- mem_addr  out  32  = alu_result
- mem_wd  out  32  = rd2
- alu_result  out  32  ALU output
- zero  out  1  alu_result == 0

Behaviour:
- PC: pc_q <= pc_d on rising clock; async reset sets pc_q = RESET_PC immediately. Reset has priority over the clock and is honoured mid-instruction. All other outputs follow pc_q/instr combinationally.
- Decode, opcode instr[31:26]:
  - 000000 R-type: reg_write=1, wa3=instr[15:11], SrcB=rd2.
  - 100011 lw: reg_write=1, wa3=rt, SrcB=imm, ADD, wd3=mem_rd.
  - 101011 sw: mem_write=1, SrcB=imm, ADD.
  - 000100 beq: SUB, branch.
  - 001000 addi: reg_write=1, wa3=rt, SrcB=imm, ADD.
  - 000010 j: jump only.
  - 000011 jal: jump; reg_write=1, wa3=LINK_REG, wd3=pc_q+4.
- R-type funct instr[5:0]: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt, 001000 jr.
- jr: reg_write=0; ra1 forced to LINK_REG regardless of rs; pc_d = rd1.
- Undefined opcode or funct: reg_write=0, mem_write=0, pc_d = pc_q+4.
- ra1 = instr[25:21] except jr.
- imm = sign-extended instr[15:0] for every I-type.
- ALU control codes (5 bits): AND 00000, OR 00001, ADD 00010, SUB 00110, SLT 00111, NOR 01100. Any other code gives result 0.
- ALU arithmetic: SrcA=rd1. Add/sub wrap modulo 2^32, no overflow flag. SLT is signed and returns 32'd1 or 32'd0.
- Non-jal, non-lw wd3 = alu_result.
- Next PC, in priority order:
  1. jr → rd1 (no alignment forcing).
  2. j/jal → {pcplus4[31:28], instr[25:0], 2'b00}.
  3. beq & zero → pcplus4 + (imm << 2).
  4. Otherwise pcplus4.
- All adders wrap modulo 2^32; PC wrap from 32'hFFFF_FFFC gives 0.

Decomposition:
- Package mips_pkg holds: opcode constants, funct constants, 5-bit ALU control codes, and LINK_REG default.
- One sub-module, exec_alu: pure combinational, inputs a, b, ctrl; outputs result, zero.
- Decoder, adders and muxes stay inline in mips_core_exec.

Test Plan:
- Reset: assert reset mid-cycle → pc_q = 0 immediately. After release, each clock with instr = add gives pc_q 4, 8, 12.
- R-type add/sub/slt: rd1=32'hFFFF_FFFF, rd2=1.
  - add → alu_result = 0, zero = 1.
  - sub → 32'hFFFF_FFFE.
  - slt → 1.
  - reg_write = 1, wa3 = instr[15:11].
- lw/sw at pc_q=8, instr=8C22FFFC, rd1=0x100:
  - lw: mem_addr = 0xFC, wd3 = mem_rd, wa3 = 2, reg_write = 1.
  - sw (opcode 101011), same fields: mem_write = 1, reg_write = 0, mem_wd = rd2.
- beq at pc_q=0x10, imm=3:
  - rd1 == rd2 → pc_d = 0x20.
  - rd1 != rd2 → pc_d = 0x14.
- jal at pc_q=0x40, target field 0x10 → pc_d = 0x40, wa3 = 7, wd3 = 0x44, reg_write = 1. Then jr (funct 001000), rs=3, rd1=0x44 → ra1 = 7, pc_d = 0x44, reg_write = 0.
- Illegal opcode 111111 → reg_write = 0, mem_write = 0, pc_d = pc_q + 4. ALU code 11111 → alu_result = 0, zero = 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS-subset execution core.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_NOR = 5'b01100;
  localparam logic [4:0] ALU_NOP = 5'b11111;

  localparam logic [4:0] LINK_REG_DEF = 5'd7;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       alu_imm;
    logic [4:0] alu_ctrl;
    logic       branch;
    logic       jump;
    logic       jr;
    logic       link;
    logic       mem_to_reg;
    logic       reg_dst;
  } ctrl_t;
endpackage

// File: rtl/mips_core_exec_alu.sv
// 32-bit combinational ALU; unknown control codes yield zero.
module exec_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  ctrl,
  output logic [31:0] result,
  output logic        zero
);
  always_comb begin
    result = 32'd0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_NOR: result = ~(a | b);
      default: result = 32'd0;
    endcase
  end

  assign zero = (result == 32'd0);
endmodule

// File: rtl/mips_core_exec.sv
// Single-cycle MIPS-subset execute core: decode, ALU, PC and next-PC/writeback muxing.
module mips_core_exec
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [4:0]  LINK_REG = LINK_REG_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] mem_rd,
  output logic [31:0] pc_q,
  output logic [31:0] pc_d,
  output logic [4:0]  ra1,
  output logic [4:0]  ra2,
  output logic [4:0]  wa3,
  output logic        reg_write,
  output logic [31:0] wd3,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [31:0] alu_result,
  output logic        zero
);
  logic [31:0] r_pc;
  ctrl_t       w_ctl;
  logic [5:0]  w_op, w_fn;
  logic [31:0] w_imm, w_srcb, w_pcplus4, w_pcbr;
  logic        w_unused_shamt;

  assign w_op  = instr[31:26];
  assign w_fn  = instr[5:0];
  assign w_imm = {{16{instr[15]}}, instr[15:0]};
  assign w_unused_shamt = ^instr[10:6];

  always_comb begin
    w_ctl          = '0;
    w_ctl.alu_ctrl = ALU_NOP;
    case (w_op)
      OP_RTYPE: begin
        w_ctl.reg_dst   = 1'b1;
        w_ctl.reg_write = 1'b1;
        case (w_fn)
          FN_ADD:  w_ctl.alu_ctrl = ALU_ADD;
          FN_SUB:  w_ctl.alu_ctrl = ALU_SUB;
          FN_AND:  w_ctl.alu_ctrl = ALU_AND;
          FN_OR:   w_ctl.alu_ctrl = ALU_OR;
          FN_NOR:  w_ctl.alu_ctrl = ALU_NOR;
          FN_SLT:  w_ctl.alu_ctrl = ALU_SLT;
          FN_JR: begin
            w_ctl.reg_write = 1'b0;
            w_ctl.jr        = 1'b1;
          end
          default: w_ctl.reg_write = 1'b0;
        endcase
      end
      OP_LW: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.alu_imm    = 1'b1;
        w_ctl.alu_ctrl   = ALU_ADD;
        w_ctl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        w_ctl.mem_write = 1'b1;
        w_ctl.alu_imm   = 1'b1;
        w_ctl.alu_ctrl  = ALU_ADD;
      end
      OP_BEQ: begin
        w_ctl.alu_ctrl = ALU_SUB;
        w_ctl.branch   = 1'b1;
      end
      OP_ADDI: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.alu_imm   = 1'b1;
        w_ctl.alu_ctrl  = ALU_ADD;
      end
      OP_J:   w_ctl.jump = 1'b1;
      OP_JAL: begin
        w_ctl.jump      = 1'b1;
        w_ctl.link      = 1'b1;
        w_ctl.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_srcb = w_ctl.alu_imm ? w_imm : rd2;

  exec_alu u_alu (
    .a      (rd1),
    .b      (w_srcb),
    .ctrl   (w_ctl.alu_ctrl),
    .result (alu_result),
    .zero   (zero)
  );

  assign w_pcplus4 = r_pc + 32'd4;
  assign w_pcbr    = w_pcplus4 + (w_imm << 2);

  // jr outranks jumps, which outrank a taken branch.
  always_comb begin
    pc_d = w_pcplus4;
    if (w_ctl.jr)                  pc_d = rd1;
    else if (w_ctl.jump)           pc_d = {w_pcplus4[31:28], instr[25:0], 2'b00};
    else if (w_ctl.branch && zero) pc_d = w_pcbr;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_pc <= RESET_PC;
    else       r_pc <= pc_d;
  end

  assign pc_q      = r_pc;
  assign ra1       = w_ctl.jr ? LINK_REG : instr[25:21];
  assign ra2       = instr[20:16];
  assign wa3       = w_ctl.link ? LINK_REG : (w_ctl.reg_dst ? instr[15:11] : instr[20:16]);
  assign wd3       = w_ctl.link ? w_pcplus4 : (w_ctl.mem_to_reg ? mem_rd : alu_result);
  assign reg_write = w_ctl.reg_write;
  assign mem_write = w_ctl.mem_write;
  assign mem_addr  = alu_result;
  assign mem_wd    = rd2;
endmodule

// File: tb/tb_mips_core_exec.sv
// Directed self-checking bench for mips_core_exec.
module tb_mips_core_exec;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr, rd1, rd2, mem_rd;
  logic [31:0] pc_q, pc_d, wd3, mem_addr, mem_wd, alu_result;
  logic [4:0]  ra1, ra2, wa3;
  logic        reg_write, mem_write, zero;
  logic [31:0] a_a, a_b, a_res;
  logic [4:0]  a_ctrl;
  logic        a_zero;
  int          total = 0;
  int          bad   = 0;

  localparam logic [31:0] I_ADD = 32'h0022_1820;
  localparam logic [31:0] I_SUB = 32'h0022_1822;
  localparam logic [31:0] I_AND = 32'h0022_1824;
  localparam logic [31:0] I_OR  = 32'h0022_1825;
  localparam logic [31:0] I_NOR = 32'h0022_1827;
  localparam logic [31:0] I_SLT = 32'h0022_182A;
  localparam logic [31:0] I_LW  = 32'h8C22_FFFC;
  localparam logic [31:0] I_SW  = 32'hAC22_FFFC;
  localparam logic [31:0] I_BEQ = 32'h1022_0003;
  localparam logic [31:0] I_J   = 32'h0800_0010;
  localparam logic [31:0] I_JAL = 32'h0C00_0010;
  localparam logic [31:0] I_JR  = 32'h0060_0008;
  localparam logic [31:0] I_BAD = 32'hFC00_0000;

  always #5 clock = ~clock;

  mips_core_exec dut (
    .clock(clock), .reset(reset), .instr(instr), .rd1(rd1), .rd2(rd2), .mem_rd(mem_rd),
    .pc_q(pc_q), .pc_d(pc_d), .ra1(ra1), .ra2(ra2), .wa3(wa3), .reg_write(reg_write),
    .wd3(wd3), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .alu_result(alu_result), .zero(zero)
  );

  exec_alu u_alu_chk (.a(a_a), .b(a_b), .ctrl(a_ctrl), .result(a_res), .zero(a_zero));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; instr = I_ADD; rd1 = 32'd0; rd2 = 32'd0; mem_rd = 32'd0;
    a_a = 32'd5; a_b = 32'd3; a_ctrl = 5'b11111;
    #3;
    chk("reset_pc", pc_q, 32'h0);
    reset = 1'b0;
    tick(); chk("pc_after1", pc_q, 32'h4);
    tick(); chk("pc_after2", pc_q, 32'h8);
    #1 reset = 1'b1;
    #1 chk("async_reset_pc", pc_q, 32'h0);
    chk("reset_pc_d", pc_d, 32'h4);
    #1 reset = 1'b0;
    tick(); chk("pc_seq4", pc_q, 32'h4);
    tick(); chk("pc_seq8", pc_q, 32'h8);

    // R-type ops at pc 8
    rd1 = 32'hFFFF_FFFF; rd2 = 32'd1;
    #1 chk("add_res", alu_result, 32'h0);
    chk("add_zero", {31'd0, zero}, 32'd1);
    chk("add_rw", {31'd0, reg_write}, 32'd1);
    chk("add_wa3", {27'd0, wa3}, 32'd3);
    chk("add_wd3", wd3, 32'h0);
    chk("add_ra1", {27'd0, ra1}, 32'd1);
    chk("add_ra2", {27'd0, ra2}, 32'd2);
    instr = I_SUB;
    #1 chk("sub_res", alu_result, 32'hFFFF_FFFE);
    chk("sub_zero", {31'd0, zero}, 32'd0);
    instr = I_SLT;
    #1 chk("slt_res", alu_result, 32'h1);
    instr = I_AND;
    #1 chk("and_res", alu_result, 32'h1);
    instr = I_OR;
    #1 chk("or_res", alu_result, 32'hFFFF_FFFF);
    instr = I_NOR;
    #1 chk("nor_res", alu_result, 32'h0);

    // lw / sw at pc 8
    instr = I_LW; rd1 = 32'h100; rd2 = 32'hDEAD_BEEF; mem_rd = 32'h1234_5678;
    #1 chk("lw_addr", mem_addr, 32'hFC);
    chk("lw_wd3", wd3, 32'h1234_5678);
    chk("lw_wa3", {27'd0, wa3}, 32'd2);
    chk("lw_rw", {31'd0, reg_write}, 32'd1);
    chk("lw_mw", {31'd0, mem_write}, 32'd0);
    chk("lw_pcd", pc_d, 32'hC);
    instr = I_SW;
    #1 chk("sw_mw", {31'd0, mem_write}, 32'd1);
    chk("sw_rw", {31'd0, reg_write}, 32'd0);
    chk("sw_wd", mem_wd, 32'hDEAD_BEEF);
    chk("sw_addr", mem_addr, 32'hFC);

    instr = I_ADD;
    tick(); chk("pc_12", pc_q, 32'hC);
    tick(); chk("pc_16", pc_q, 32'h10);

    // beq at pc 0x10, imm 3
    instr = I_BEQ; rd1 = 32'h55; rd2 = 32'h56;
    #1 chk("beq_nt_pcd", pc_d, 32'h14);
    chk("beq_rw", {31'd0, reg_write}, 32'd0);
    rd2 = 32'h55;
    #1 chk("beq_t_pcd", pc_d, 32'h20);
    tick(); chk("beq_pc", pc_q, 32'h20);

    instr = I_J;
    #1 chk("j_pcd", pc_d, 32'h40);
    chk("j_rw", {31'd0, reg_write}, 32'd0);
    tick(); chk("j_pc", pc_q, 32'h40);

    instr = I_JAL;
    #1 chk("jal_pcd", pc_d, 32'h40);
    chk("jal_wa3", {27'd0, wa3}, 32'd7);
    chk("jal_wd3", wd3, 32'h44);
    chk("jal_rw", {31'd0, reg_write}, 32'd1);
    tick(); chk("jal_pc", pc_q, 32'h40);

    instr = I_JR; rd1 = 32'h44;
    #1 chk("jr_ra1", {27'd0, ra1}, 32'd7);
    chk("jr_pcd", pc_d, 32'h44);
    chk("jr_rw", {31'd0, reg_write}, 32'd0);
    tick(); chk("jr_pc", pc_q, 32'h44);

    instr = I_BAD;
    #1 chk("bad_rw", {31'd0, reg_write}, 32'd0);
    chk("bad_mw", {31'd0, mem_write}, 32'd0);
    chk("bad_pcd", pc_d, 32'h48);
    chk("bad_res", alu_result, 32'h0);

    instr = 32'h0022_183F;
    #1 chk("badfn_rw", {31'd0, reg_write}, 32'd0);
    chk("badfn_pcd", pc_d, 32'h48);

    chk("alu_nop_res", a_res, 32'h0);
    chk("alu_nop_zero", {31'd0, a_zero}, 32'd1);

    // PC wrap through 0xFFFF_FFFC
    instr = I_JR; rd1 = 32'hFFFF_FFFC;
    tick(); chk("wrap_pc", pc_q, 32'hFFFF_FFFC);
    instr = I_ADD;
    #1 chk("wrap_pcd", pc_d, 32'h0);
    tick(); chk("wrap_pc0", pc_q, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
